// File: rtl/mmap_m_axi_reg_slice_pipe_pkg.sv
// Shared definitions for the m_axi register-slice pipeline.
//   MODE_*      : slice type encodings (bypass, full skid, forward-only, reverse-only)
//   ST_*        : full-skid stage state encodings (value equals beats held)
//   occ_width() : width of the occupancy count for a given number of stages
package mmap_m_axi_reg_slice_pipe_pkg;

    localparam int MODE_BYPASS = 0;
    localparam int MODE_FULL   = 1;
    localparam int MODE_FWD    = 2;
    localparam int MODE_REV    = 3;

    localparam logic [1:0] ST_ZERO = 2'd0;
    localparam logic [1:0] ST_ONE  = 2'd1;
    localparam logic [1:0] ST_TWO  = 2'd2;

    function automatic int occ_width(input int num_stages);
        return $clog2(2 * num_stages + 1);
    endfunction

endpackage

// File: rtl/mmap_m_axi_reg_slice_pipe_stage.sv
// One register-slice stage of a valid/ready pipeline.
//   clk, reset        : clock, synchronous active-high reset
//   s_data/valid/ready: upstream handshake
//   m_data/valid/ready: downstream handshake
//   count             : beats currently held in this stage (0..2)
module mmap_m_axi_reg_slice_stage
    import mmap_m_axi_reg_slice_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MODE       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            count
);

    if (MODE < MODE_BYPASS || MODE > MODE_REV) begin : g_bad_mode
        $error("mmap_m_axi_reg_slice_stage: illegal MODE %0d", MODE);
    end

    if (MODE == MODE_FULL) begin : g_full
        logic [1:0]            state;
        logic [1:0]            state_next;
        logic [DATA_WIDTH-1:0] main_data;
        logic [DATA_WIDTH-1:0] skid_data;
        logic                  ready_r;
        logic                  valid_r;

        always_comb begin
            state_next = state;
            case (state)
                ST_ZERO: if (s_valid && ready_r) state_next = ST_ONE;
                ST_ONE: begin
                    if (m_ready && !s_valid)      state_next = ST_ZERO;
                    else if (s_valid && !m_ready) state_next = ST_TWO;
                end
                ST_TWO:  if (m_ready) state_next = ST_ONE;
                default: state_next = ST_ZERO;
            endcase
        end

        // Ready and valid are registered copies derived from the next state,
        // so neither output has a combinational path from the other side.
        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= ST_ZERO;
                ready_r <= 1'b0;
                valid_r <= 1'b0;
            end else begin
                state   <= state_next;
                ready_r <= (state_next != ST_TWO);
                valid_r <= (state_next != ST_ZERO);
            end
        end

        always_ff @(posedge clk) begin
            if (state == ST_TWO) begin
                if (m_ready) main_data <= skid_data;
            end else if (s_valid && ready_r) begin
                if (state == ST_ZERO || m_ready) main_data <= s_data;
                else                             skid_data <= s_data;
            end
        end

        assign s_ready = ready_r;
        assign m_valid = valid_r;
        assign m_data  = main_data;
        // State encoding doubles as the held-beat count.
        assign count   = state;
    end else if (MODE == MODE_FWD) begin : g_fwd
        logic                  valid_r;
        logic [DATA_WIDTH-1:0] data_r;

        assign s_ready = !valid_r || m_ready;

        always_ff @(posedge clk) begin
            if (reset)        valid_r <= 1'b0;
            else if (s_ready) valid_r <= s_valid;
        end

        always_ff @(posedge clk) begin
            if (s_ready && s_valid) data_r <= s_data;
        end

        assign m_valid = valid_r;
        assign m_data  = data_r;
        assign count   = {1'b0, valid_r};
    end else if (MODE == MODE_REV) begin : g_rev
        logic                  skid_valid;
        logic                  skid_next;
        logic                  ready_r;
        logic [DATA_WIDTH-1:0] skid_data;

        always_comb begin
            skid_next = skid_valid;
            if (skid_valid && m_ready)                  skid_next = 1'b0;
            else if (s_valid && ready_r && !m_ready)    skid_next = 1'b1;
        end

        // ready_r mirrors ~skid_valid, but is held low through reset so the
        // stage only starts accepting one cycle after reset releases.
        always_ff @(posedge clk) begin
            if (reset) begin
                skid_valid <= 1'b0;
                ready_r    <= 1'b0;
            end else begin
                skid_valid <= skid_next;
                ready_r    <= !skid_next;
            end
        end

        always_ff @(posedge clk) begin
            if (s_valid && ready_r && !m_ready) skid_data <= s_data;
        end

        // Pass-through beats are gated by ready_r so a beat is never offered
        // downstream before upstream sees it accepted.
        assign s_ready = ready_r;
        assign m_valid = skid_valid || (s_valid && ready_r);
        assign m_data  = skid_valid ? skid_data : s_data;
        assign count   = {1'b0, skid_valid};
    end else begin : g_bypass
        logic unused_sync;
        assign unused_sync = clk ^ reset;
        assign s_ready = m_ready;
        assign m_valid = s_valid;
        assign m_data  = s_data;
        assign count   = '0;
    end

endmodule

// File: rtl/mmap_m_axi_reg_slice_pipe.sv
// Cascade of NUM_STAGES register slices on a valid/ready stream.
//   clk, reset        : clock, synchronous active-high reset
//   s_data/valid/ready: upstream handshake
//   m_data/valid/ready: downstream handshake
//   occupancy         : total beats held across all stages
//   idle              : high when occupancy is zero
module mmap_m_axi_reg_slice_pipe
    import mmap_m_axi_reg_slice_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MODE       = 1,
    parameter int NUM_STAGES = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_WIDTH-1:0]                s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [DATA_WIDTH-1:0]                m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [occ_width(NUM_STAGES)-1:0]     occupancy,
    output logic                                 idle
);

    localparam int OW = occ_width(NUM_STAGES);

    if (MODE < MODE_BYPASS || MODE > MODE_REV) begin : g_bad_mode
        $error("mmap_m_axi_reg_slice_pipe: illegal MODE %0d", MODE);
    end
    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
        $error("mmap_m_axi_reg_slice_pipe: illegal NUM_STAGES %0d", NUM_STAGES);
    end

    if (MODE == MODE_BYPASS) begin : g_bypass
        logic unused_sync;
        assign unused_sync = clk ^ reset;
        assign m_data      = s_data;
        assign m_valid     = s_valid;
        assign s_ready     = m_ready;
        assign occupancy   = '0;
    end else begin : g_cascade
        // Each stage links to its neighbours by name so every signal has a
        // single driver; occupancy accumulates along the chain.
        for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
            logic [DATA_WIDTH-1:0] in_data;
            logic [DATA_WIDTH-1:0] out_data;
            logic                  in_valid;
            logic                  in_ready;
            logic                  out_valid;
            logic                  out_ready;
            logic [1:0]            count;
            logic [OW-1:0]         occ_acc;

            if (i == 0) begin : g_head
                assign in_data  = s_data;
                assign in_valid = s_valid;
                assign occ_acc  = OW'(count);
            end else begin : g_link
                assign in_data  = g_stage[i-1].out_data;
                assign in_valid = g_stage[i-1].out_valid;
                assign occ_acc  = g_stage[i-1].occ_acc + OW'(count);
            end

            if (i == NUM_STAGES - 1) begin : g_tail
                assign out_ready = m_ready;
            end else begin : g_next
                assign out_ready = g_stage[i+1].in_ready;
            end

            mmap_m_axi_reg_slice_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .MODE       (MODE)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .s_data  (in_data),
                .s_valid (in_valid),
                .s_ready (in_ready),
                .m_data  (out_data),
                .m_valid (out_valid),
                .m_ready (out_ready),
                .count   (count)
            );
        end

        assign s_ready   = g_stage[0].in_ready;
        assign m_data    = g_stage[NUM_STAGES-1].out_data;
        assign m_valid   = g_stage[NUM_STAGES-1].out_valid;
        assign occupancy = g_stage[NUM_STAGES-1].occ_acc;
    end

    assign idle = (occupancy == '0);

endmodule
